// File: rtl/adc_lane_tx.sv
// rtl/adc_lane_tx.sv - LVDS ADC link transmit emulator: frame-clock and data lane words with programmable bit rotation
module adc_lane_tx #(
    parameter logic [7:0] FCO_PATTERN = 8'hF0,
    parameter logic [7:0] TRAIN_WORD  = 8'hA5,
    parameter logic [7:0] IDLE_WORD   = 8'h00,
    parameter int         TRAIN_LEN   = 16,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       CLKDIV,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] slip_offset,
    input  logic       ramp_en,
    input  logic [7:0] sample_data,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic [7:0] OSERDES_FCO,
    output logic [7:0] OSERDES_D,
    output logic       training,
    output logic       busy,
    output logic [7:0] underflow_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, TRAIN, STREAM} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2:0]     k;
    logic [7:0]     train_cnt;
    logic [7:0]     ramp;
    logic [7:0]     d_word;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic           push;
    logic           pop;
    logic           flush;

    function automatic logic [7:0] rot(input logic [7:0] w, input logic [2:0] n);
        logic [15:0] dbl;
        dbl = {w, w} << n;
        return dbl[15:8];
    endfunction

    always_comb begin
        flush     = stop && (state != IDLE);
        push      = sample_valid && sample_ready;
        pop       = (state == STREAM) && !stop && !ramp_en && (count != '0);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = TRAIN;
            TRAIN: begin
                if (stop)
                    state_nxt = IDLE;
                else if (train_cnt == 8'(TRAIN_LEN - 1))
                    state_nxt = STREAM;
            end
            STREAM:  if (stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
    end

    // Sample storage has no reset; occupancy and pointers define validity.
    always_ff @(posedge CLKDIV) begin
        if (push && !flush)
            mem[wr_ptr] <= sample_data;
    end

    always_ff @(posedge CLKDIV) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            train_cnt     <= '0;
            ramp          <= '0;
            d_word        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            underflow_cnt <= '0;
            OSERDES_FCO   <= '0;
            OSERDES_D     <= '0;
            sample_ready  <= 1'b0;
            training      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state        <= state_nxt;
            training     <= (state_nxt == TRAIN);
            busy         <= (state_nxt != IDLE);
            sample_ready <= (state_nxt != IDLE) && (count_nxt != CW'(FIFO_DEPTH));
            count        <= count_nxt;
            OSERDES_FCO  <= rot(FCO_PATTERN, k);
            // Data word is chosen one edge before it is rotated onto the lane.
            OSERDES_D    <= rot(d_word, k);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            d_word <= IDLE_WORD;
            case (state)
                IDLE: begin
                    if (start) begin
                        k         <= slip_offset;
                        train_cnt <= '0;
                    end
                end
                TRAIN: begin
                    if (!stop) begin
                        d_word    <= TRAIN_WORD;
                        train_cnt <= train_cnt + 8'd1;
                        if (state_nxt == STREAM) ramp <= '0;
                    end
                end
                STREAM: begin
                    if (!stop) begin
                        if (ramp_en) begin
                            d_word <= ramp;
                            ramp   <= ramp + 8'd1;
                        end else if (pop) begin
                            d_word <= mem[rd_ptr];
                        end else if (underflow_cnt != 8'hFF) begin
                            underflow_cnt <= underflow_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_lane_tx.sv
// tb/tb_adc_lane_tx.sv - self-checking bench for adc_lane_tx
module tb_adc_lane_tx;

    logic       CLKDIV;
    logic       rst;
    logic       start;
    logic       stop;
    logic [2:0] slip_offset;
    logic       ramp_en;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] OSERDES_FCO;
    logic [7:0] OSERDES_D;
    logic       training;
    logic       busy;
    logic [7:0] underflow_cnt;

    adc_lane_tx dut (
        .CLKDIV        (CLKDIV),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .slip_offset   (slip_offset),
        .ramp_en       (ramp_en),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .OSERDES_FCO   (OSERDES_FCO),
        .OSERDES_D     (OSERDES_D),
        .training      (training),
        .busy          (busy),
        .underflow_cnt (underflow_cnt)
    );

    typedef struct {
        logic [2:0] slip;
        logic [7:0] fco;
        logic [7:0] trn;
        logic [7:0] r1;
    } row_t;

    typedef struct {
        logic [7:0] val;
        int         due;
    } sb_t;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic       sb_en    = 1'b0;
    logic       last_acc = 1'b0;
    logic [7:0] ramp_m   = 8'h00;
    logic [7:0] uf_m     = 8'h00;
    logic [7:0] mq[$];
    sb_t        chk_q[$];
    row_t       rows[5];

    initial begin
        CLKDIV = 1'b0;
        forever #5 CLKDIV = ~CLKDIV;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %02h, expected %02h", nm, cyc, act, exp);
        end
    endtask

    // One clock: advance the STREAM model on the edge, then compare due results.
    task automatic tick();
        logic [7:0] ent;
        sb_t        e;
        last_acc = 1'b0;
        if (sb_en) begin
            last_acc = sample_valid && (mq.size() < 4);
            if (ramp_en) begin
                ent    = ramp_m;
                ramp_m = ramp_m + 8'd1;
            end else if (mq.size() > 0) begin
                ent = mq.pop_front();
            end else begin
                ent = 8'h00;
                if (uf_m != 8'hFF) uf_m = uf_m + 8'd1;
            end
            if (last_acc) mq.push_back(sample_data);
            e.val = ent;
            e.due = cyc + 2;
            chk_q.push_back(e);
        end
        @(posedge CLKDIV);
        cyc++;
        #1;
        if (chk_q.size() > 0 && chk_q[0].due == cyc) begin
            e = chk_q.pop_front();
            chk("stream_d", OSERDES_D, e.val);
        end
        if (sb_en) begin
            chk("ready", 8'(sample_ready), 8'(mq.size() < 4));
            chk("underflow_cnt", underflow_cnt, uf_m);
        end
    endtask

    task automatic train_check(input row_t r, input logic use_ramp);
        logic [7:0] exp_d;
        ramp_en     = use_ramp;
        slip_offset = r.slip;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        slip_offset = 3'd6;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) tick();
            if (j < 2)        exp_d = 8'h00;
            else if (j <= 17) exp_d = r.trn;
            else if (j == 18) exp_d = 8'h00;
            else              exp_d = use_ramp ? r.r1 : 8'h00;
            chk("train_d", OSERDES_D, exp_d);
            chk("training", 8'(training), 8'(j < 16));
            chk("busy_train", 8'(busy), 8'h01);
            if (j > 0) chk("fco", OSERDES_FCO, r.fco);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("busy_after_stop", 8'(busy), 8'h00);
        chk("ready_after_stop", 8'(sample_ready), 8'h00);
        tick();
        chk("idle_d_after_stop", OSERDES_D, 8'h00);
        chk("fco_retained", OSERDES_FCO, r.fco);
    endtask

    task automatic push_words(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                              input logic [7:0] w3, input logic [7:0] w4, input int n, input int budget);
        logic [7:0] vals[5];
        int         idx;
        vals[0] = w0; vals[1] = w1; vals[2] = w2; vals[3] = w3; vals[4] = w4;
        idx = 0;
        sample_valid = 1'b1;
        sample_data  = vals[0];
        for (int t = 0; t < budget && idx < n; t++) begin
            tick();
            if (last_acc) idx++;
            if (idx < n) sample_data = vals[idx];
        end
        sample_valid = 1'b0;
        if (idx < n) begin
            n_assert++;
            n_fail++;
            $display("FAIL push_timeout: accepted %0d, expected %0d", idx, n);
        end
    endtask

    initial begin
        rows[0] = '{slip: 3'd0, fco: 8'hF0, trn: 8'hA5, r1: 8'h01};
        rows[1] = '{slip: 3'd1, fco: 8'hE1, trn: 8'h4B, r1: 8'h02};
        rows[2] = '{slip: 3'd4, fco: 8'h0F, trn: 8'h5A, r1: 8'h10};
        rows[3] = '{slip: 3'd7, fco: 8'h78, trn: 8'hD2, r1: 8'h80};
        rows[4] = '{slip: 3'd3, fco: 8'h87, trn: 8'h2D, r1: 8'h08};

        rst = 1'b1; start = 1'b0; stop = 1'b0; slip_offset = 3'd0;
        ramp_en = 1'b1; sample_data = 8'h00; sample_valid = 1'b0;
        repeat (3) tick();
        chk("rst_fco", OSERDES_FCO, 8'h00);
        chk("rst_d", OSERDES_D, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_ready", 8'(sample_ready), 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_fco", OSERDES_FCO, 8'hF0);
            chk("idle_d", OSERDES_D, 8'h00);
            chk("idle_busy", 8'(busy), 8'h00);
            chk("idle_ready", 8'(sample_ready), 8'h00);
            chk("idle_training", 8'(training), 8'h00);
        end

        for (int r = 0; r < 5; r++) train_check(rows[r], 1'b1);

        // Enter STREAM with k = 0 and hand the data lane to the model.
        ramp_en = 1'b1; slip_offset = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        ramp_m = 8'h00;
        mq.delete();
        chk_q.delete();
        sb_en = 1'b1;

        repeat (260) tick();

        push_words(8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 4, 8);
        chk("full_ready_low", 8'(sample_ready), 8'h00);
        ramp_en = 1'b0;
        push_words(8'h65, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8);
        repeat (8) tick();

        push_words(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 5, 5);
        repeat (4) tick();

        repeat (300) tick();
        chk("uf_saturated", underflow_cnt, 8'hFF);

        ramp_en = 1'b1;
        push_words(8'h71, 8'h72, 8'h73, 8'h00, 8'h00, 3, 6);
        sb_en = 1'b0;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
        mq.delete();
        chk_q.delete();
        chk("flush_busy", 8'(busy), 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_idle_d", OSERDES_D, 8'h00);
            chk("flush_ready", 8'(sample_ready), 8'h00);
        end
        train_check(rows[0], 1'b0);
        chk("uf_kept", underflow_cnt, 8'hFF);

        slip_offset = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midrst_fco", OSERDES_FCO, 8'h00);
        chk("midrst_d", OSERDES_D, 8'h00);
        chk("midrst_busy", 8'(busy), 8'h00);
        chk("midrst_training", 8'(training), 8'h00);
        chk("midrst_ready", 8'(sample_ready), 8'h00);
        chk("midrst_uf", underflow_cnt, 8'h00);
        rst = 1'b0;
        tick();
        chk("post_rst_fco", OSERDES_FCO, 8'hF0);
        chk("post_rst_d", OSERDES_D, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
